// File: rtl/data_mem_port.sv
// data_mem_port: bridges single-cycle core load/store controls to a
// wait-stated request/response memory bus, stalling the core per access.
// Optional feature macro: DATA_MEM_PORT_TIMEOUT_EN (response-wait timeout).
module data_mem_port #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misalign,
  output logic              timeout_err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t state, state_next;
  logic   access, misaligned_access, aligned_access;
  logic   to_hit;

  // Elaboration-time guard on the timeout limit range
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("data_mem_port: TIMEOUT_CYCLES must be in 1..255");
  end

  // Classify the access presented by the core this cycle
  always_comb begin
    access            = mem_read | mem_write;
    misaligned_access = access & (addr[1:0] != 2'b00);
    aligned_access    = access & ~misaligned_access;
  end

`ifdef DATA_MEM_PORT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt;

  // Limit is reached on the cycle whose missing response would make the count hit TIMEOUT_CYCLES
  assign to_hit = (state == WAIT_RSP) & ~rsp_valid & (to_cnt == TO_LAST);

  // Response-wait counter: held at zero outside WAIT_RSP so it is clear on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (state != WAIT_RSP) begin
        to_cnt <= 8'd0;
      end else if (!rsp_valid) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and combinational stall
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_access) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (req_ready) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (rsp_valid || to_hit) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered bus/result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= '0;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      misalign  <= 1'b0;
    end else begin
      state     <= state_next;
      req_valid <= (state_next == REQ);
      misalign  <= (state == IDLE) & misaligned_access;
      if (state == IDLE && aligned_access) begin
        req_we    <= mem_write;
        req_addr  <= {addr[ADDR_W-1:2], 2'b00};
        req_wdata <= wdata;
      end
      if (state == WAIT_RSP && !req_we) begin
        if (rsp_valid) begin
          rdata <= rsp_data;
        end else if (to_hit) begin
          rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed, self-checking bench for data_mem_port with a request/response scoreboard.
module tb_data_mem_port;

`ifdef DATA_MEM_PORT_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign, timeout_err;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  req_t        req_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;

  data_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign(misalign), .timeout_err(timeout_err), .req_valid(req_valid),
    .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load/store with bench-chosen handshake delays; timing derived from the protocol
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                            input logic [31:0] rsp_d);
    req_t e;
    req_q.push_back('{we: wr, addr: {a[31:2], 2'b00}, wdata: wd});
    exp_q.push_back(wr ? model_rdata : rsp_d);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    #1;
    check("idle_stall", stall, 1);
    check("idle_req_valid", req_valid, 0);
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      req_ready = (i == rdy_dly);
      #1;
      e = req_q[0];
      check("req_valid", req_valid, 1);
      check("req_we", req_we, e.we);
      check("req_addr", req_addr, e.addr);
      check("req_wdata", req_wdata, e.wdata);
      check("req_stall", stall, 1);
      if (i == rdy_dly) void'(req_q.pop_front());
      tick();
    end
    req_ready = 1'b0;
    for (int j = 0; j <= rsp_dly; j++) begin
      rsp_valid = (j == rsp_dly);
      rsp_data  = (j == rsp_dly) ? rsp_d : 32'hBAD0_0000 | 32'(j);
      #1;
      check("wait_req_valid", req_valid, 0);
      check("wait_stall", stall, 1);
      tick();
    end
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    #1;
    model_rdata = exp_q.pop_front();
    check("done_stall", stall, 0);
    check("done_rdata", rdata, model_rdata);
    check("done_timeout_err", timeout_err, 0);
    check("done_req_valid", req_valid, 0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check("after_stall", stall, 0);
    check("after_req_valid", req_valid, 0);
    check("after_rdata", rdata, model_rdata);
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    model_rdata = 32'h0;
    tick();
    tick();
    check("rst_rdata", rdata, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_we", req_we, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_wdata", req_wdata, 0);
    check("rst_misalign", misalign, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;
    tick();

    // Minimum-latency load
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'hCAFEF00D);
    tick();

    // Store with slow ready and slow response; rsp_data must be ignored
    run_access(1'b0, 1'b1, 32'h24, 32'h12345678, 2, 2, 32'h0BADBEEF);
    tick();

    // Misaligned load: pulse only, no request, no stall
    mem_read = 1'b1; addr = 32'h102;
    #1;
    check("mis_stall", stall, 0);
    check("mis_req_valid", req_valid, 0);
    tick();
    mem_read = 1'b0; addr = '0;
    #1;
    check("mis_pulse", misalign, 1);
    check("mis_req_valid1", req_valid, 0);
    check("mis_rdata", rdata, model_rdata);
    tick();
    check("mis_pulse_end", misalign, 0);
    check("mis_req_valid2", req_valid, 0);
    tick();

    // Both requests asserted: write wins
    run_access(1'b1, 1'b1, 32'h8, 32'hA5A5_5A5A, 0, 0, 32'h1111_2222);
    tick();

    // No response: timeout when enabled, indefinite wait otherwise
    mem_read = 1'b1; addr = 32'h40;
    #1;
    check("to_idle_stall", stall, 1);
    tick();
    req_ready = 1'b1;
    #1;
    check("to_req_valid", req_valid, 1);
    tick();
    req_ready = 1'b0;
`ifdef DATA_MEM_PORT_TIMEOUT_EN
    for (int j = 0; j < int'(TO); j++) begin
      #1;
      check("to_wait_stall", stall, 1);
      check("to_wait_err", timeout_err, 0);
      tick();
    end
    #1;
    check("to_done_stall", stall, 0);
    check("to_done_err", timeout_err, 1);
    check("to_done_rdata", rdata, 0);
    model_rdata = 32'h0;
    tick();
    mem_read = 1'b0;
    #1;
    check("to_err_end", timeout_err, 0);
    check("to_after_stall", stall, 0);
`else
    for (int j = 0; j < 60; j++) begin
      #1;
      check("nto_wait_stall", stall, 1);
      check("nto_req_valid", req_valid, 0);
      tick();
    end
    rsp_valid = 1'b1; rsp_data = 32'h5555AAAA;
    #1;
    check("nto_wait_stall_last", stall, 1);
    tick();
    rsp_valid = 1'b0; rsp_data = '0;
    #1;
    check("nto_done_stall", stall, 0);
    check("nto_done_rdata", rdata, 32'h5555AAAA);
    check("nto_done_err", timeout_err, 0);
    model_rdata = 32'h5555AAAA;
    tick();
    mem_read = 1'b0;
`endif
    tick();

    // Reset while waiting for a response; a late response must be ignored
    mem_read = 1'b1; addr = 32'h200;
    #1;
    check("rw_idle_stall", stall, 1);
    tick();
    req_ready = 1'b1;
    #1;
    check("rw_req_addr", req_addr, 32'h200);
    tick();
    req_ready = 1'b0;
    reset = 1'b1; mem_read = 1'b0;
    #1;
    check("rw_wait_stall", stall, 1);
    tick();
    reset = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hFFFFFFFF;
    #1;
    check("rw_req_valid", req_valid, 0);
    check("rw_rdata", rdata, 0);
    check("rw_stall", stall, 0);
    tick();
    rsp_valid = 1'b0; rsp_data = '0;
    #1;
    check("rw_rdata_late", rdata, 0);
    check("rw_stall_late", stall, 0);
    check("rw_req_valid_late", req_valid, 0);
    check("rw_timeout_err", timeout_err, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
